smc_sccb_master_fsm: RTL and testbench
======================================

Name: smc_sccb_master_fsm

Overview:
- Transaction sequencer for the SCCB master. Accepts one register write or read request through a valid/ready handshake.
- Enables the SIO_C timing generator and paces itself on the generator's `tick_en` and `sio_c_tgl_en` pulses.
- Drives SIO_C/SIO_D through 3-phase write or 2-phase-write + 2-phase-read cycles, then returns a one-cycle response.
- Sits between the configuration front end and the pad/tristate logic.

Parameters:
- DATA_W, 8, register address and data width. Only 8 is supported.
- ID_W, 7, slave ID width. The r/w bit is appended as the ID LSB.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  FSM idle and able to accept a request
- req_rw_i  in  1  0 = write, 1 = read
- req_id_i  in  ID_W  7-bit slave ID
- req_addr_i  in  DATA_W  sub-address
- req_wdata_i  in  DATA_W  write data (ignored for reads)
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  DATA_W  read data; holds its value until the next read completes
- busy_o  out  1  transaction in progress
- cntr_en_o  out  1  enable to the timing generator; its counter clears when this is low
- tick_en_i  in  1  mid-half-period pulse
- sio_c_tgl_en_i  in  1  end-of-half-period pulse
- sio_c_o  out  1  SIO_C level
- sio_d_o  out  1  SIO_D output value
- sio_d_oe_o  out  1  SIO_D output enable (1 = master drives)
- sio_d_i  in  1  SIO_D pad input

Behaviour:
- Single clock domain; rst is synchronous and active-high.
- Reset values: req_ready_o=1, busy_o=0, rsp_valid_o=0, rsp_rdata_o=0, cntr_en_o=0, sio_c_o=1, sio_d_o=1, sio_d_oe_o=1. All state returns to IDLE.
- Reset asserted mid-transaction aborts it on the next edge with the values above. No rsp_valid_o is produced.
- Handshake:
  - Accept when req_valid_i & req_ready_o. On accept, latch rw/id/addr/wdata and set cntr_en_o=1, busy_o=1, req_ready_o=0 from the next cycle.
  - req_valid_i is ignored while busy.
- Phase bytes:
  - ID byte = {req_id_i, rw_bit}.
  - Write: ID(w=0), ADDR, WDATA.
  - Read: ID(0), ADDR, STOP, START, ID(1), RDATA.
- States: IDLE -> START -> BIT -> STOP -> (read, first stop only) START -> BIT -> STOP -> DONE -> IDLE.
- START (one half-period, SIO_C high):
  - On tick: sio_d_o=0.
  - On tgl: sio_c_o=0, go to BIT with bit_cnt=0.
- BIT (9 bits per phase, MSB first; each bit is a low half followed by a high half):
  - Low half, on tick: set the SIO_D value for the bit.
    - Written bits 0-7: oe=1, d=bit.
    - Bit 8 of every written phase (don't-care): oe=0.
    - RDATA bits 0-7: oe=0.
    - RDATA bit 8 (NA): oe=1, d=1.
  - Low half, on tgl: sio_c_o=1.
  - High half, on tick: in RDATA bits 0-7, shift in sio_d_i.
  - High half, on tgl: sio_c_o=0. Increment bit_cnt; after bit 8, clear bit_cnt and advance the phase. After the last phase of a segment, go to STOP.
- STOP (low half, then high half):
  - Low half: tick -> oe=1, d=0; tgl -> sio_c_o=1.
  - High half: tick -> d=1; tgl -> START (read, after the first segment) or DONE.
- DONE (one cycle): cntr_en_o=0, rsp_valid_o=1. For reads, rsp_rdata_o is updated in the same cycle. Next state is IDLE with req_ready_o=1.
- Total half-periods from accept to DONE (count of tgl pulses): write = 57, read = 78.
- SIO_D changes only while SIO_C is low, except the START/STOP edges.
- If tick_en_i and sio_c_tgl_en_i are asserted in the same cycle, apply the tick action first, then the tgl action, both in that cycle.
- Pulses arriving while in IDLE or DONE are ignored.

Test Plan:
- Write: id=0x21, addr=0x12, wdata=0x80, bench timing model HCYC=8. Required: 57 tgl pulses; 27 SIO_C rising edges; SIO_D sampled at rising edges = 0x42,X,0x12,X,0x80,X (oe=0 at each X); START and STOP edges occur while SIO_C is high; rsp_valid_o pulses once.
- Read: id=0x21, addr=0x0A, slave drives 0xC5. Required: 78 tgl pulses; 36 SIO_C rising edges; repeated START between the segments; second ID byte = 0x43; NA bit driven 1; rsp_rdata_o=0xC5.
- Back-pressure: hold req_valid_i high with new data during a write. Required: req_ready_o stays 0; exactly one transaction runs; the second request is accepted in the cycle after DONE.
- Reset at the 20th tgl pulse of a write. Required: next edge has sio_c_o=1, sio_d_o=1, oe=1, cntr_en_o=0, no rsp_valid_o; a following write completes correctly.
- HCYC=1 model (tick and tgl coincident every cycle). Required: the write still produces the bit sequence above and 57 half-periods.
- Back-to-back reads 0x11 then 0x22. Required: rsp_rdata_o holds 0x11 until the second DONE, then reads 0x22.

Source files
------------

// File: rtl/smc_sccb_master_fsm.sv
// SCCB master transaction sequencer: runs one 3-phase write or 2+2-phase read
// per request, paced by the SIO_C timing generator's tick/toggle pulses.
module smc_sccb_master_fsm #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ID_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_rw_i,
    input  logic [ID_W-1:0]   req_id_i,
    input  logic [DATA_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              busy_o,
    output logic              cntr_en_o,
    input  logic              tick_en_i,
    input  logic              sio_c_tgl_en_i,
    output logic              sio_c_o,
    output logic              sio_d_o,
    output logic              sio_d_oe_o,
    input  logic              sio_d_i
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              half_q, half_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        phase_q, phase_d;
    logic              seg_q, seg_d;
    logic              rw_q, rw_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              sio_c_q, sio_c_d;
    logic              sio_d_q, sio_d_d;
    logic              oe_q, oe_d;
    logic              cntr_en_q, cntr_en_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              is_rdata;
    logic              last_phase;
    logic              last_bit;
    logic [DATA_W-1:0] cur_byte;
    logic [IDX_W-1:0]  bit_idx;

    // Segment 0 carries ID(w)/ADDR[/WDATA]; segment 1 (reads only) carries ID(r)/RDATA.
    always_comb begin
        is_rdata = seg_q && (phase_q == 2'd1);
        if (seg_q || rw_q) begin
            last_phase = (phase_q == 2'd1);
        end else begin
            last_phase = (phase_q == 2'd2);
        end
        last_bit = (bit_cnt_q == 4'(DATA_W));
        bit_idx  = IDX_W'(DATA_W - 1) - bit_cnt_q[IDX_W-1:0];
        case ({seg_q, phase_q})
            3'b000:  cur_byte = {id_q, 1'b0};
            3'b001:  cur_byte = addr_q;
            3'b010:  cur_byte = wdata_q;
            3'b100:  cur_byte = {id_q, 1'b1};
            default: cur_byte = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        bit_cnt_d   = bit_cnt_q;
        phase_d     = phase_q;
        seg_d       = seg_q;
        rw_d        = rw_q;
        id_d        = id_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        sio_c_d     = sio_c_q;
        sio_d_d     = sio_d_q;
        oe_d        = oe_q;
        cntr_en_d   = cntr_en_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;

        // Tick actions never change state/half, so a coincident toggle below
        // sees the same state and both apply in one cycle.
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && ready_q) begin
                    rw_d      = req_rw_i;
                    id_d      = req_id_i;
                    addr_d    = req_addr_i;
                    wdata_d   = req_wdata_i;
                    state_d   = S_START;
                    half_d    = 1'b0;
                    bit_cnt_d = '0;
                    phase_d   = '0;
                    seg_d     = 1'b0;
                    cntr_en_d = 1'b1;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end

            S_START: begin
                if (tick_en_i) begin
                    sio_d_d = 1'b0;
                end
                if (sio_c_tgl_en_i) begin
                    sio_c_d   = 1'b0;
                    state_d   = S_BIT;
                    half_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end

            S_BIT: begin
                if (tick_en_i) begin
                    if (!half_q) begin
                        if (is_rdata) begin
                            oe_d = last_bit;
                            if (last_bit) begin
                                sio_d_d = 1'b1;
                            end
                        end else if (last_bit) begin
                            oe_d = 1'b0;
                        end else begin
                            oe_d    = 1'b1;
                            sio_d_d = cur_byte[bit_idx];
                        end
                    end else if (is_rdata && !last_bit) begin
                        shift_d = {shift_q[DATA_W-2:0], sio_d_i};
                    end
                end
                if (sio_c_tgl_en_i) begin
                    if (!half_q) begin
                        sio_c_d = 1'b1;
                        half_d  = 1'b1;
                    end else begin
                        sio_c_d = 1'b0;
                        half_d  = 1'b0;
                        if (last_bit) begin
                            bit_cnt_d = '0;
                            if (last_phase) begin
                                state_d = S_STOP;
                            end else begin
                                phase_d = phase_q + 2'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end

            S_STOP: begin
                if (tick_en_i) begin
                    if (!half_q) begin
                        oe_d    = 1'b1;
                        sio_d_d = 1'b0;
                    end else begin
                        sio_d_d = 1'b1;
                    end
                end
                if (sio_c_tgl_en_i) begin
                    if (!half_q) begin
                        sio_c_d = 1'b1;
                        half_d  = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (rw_q && !seg_q) begin
                            state_d   = S_START;
                            seg_d     = 1'b1;
                            phase_d   = '0;
                            bit_cnt_d = '0;
                        end else begin
                            state_d     = S_DONE;
                            cntr_en_d   = 1'b0;
                            rsp_valid_d = 1'b1;
                            if (rw_q) begin
                                rdata_d = shift_q;
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            half_q      <= 1'b0;
            bit_cnt_q   <= '0;
            phase_q     <= '0;
            seg_q       <= 1'b0;
            rw_q        <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shift_q     <= '0;
            rdata_q     <= '0;
            sio_c_q     <= 1'b1;
            sio_d_q     <= 1'b1;
            oe_q        <= 1'b1;
            cntr_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            bit_cnt_q   <= bit_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            rw_q        <= rw_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            sio_c_q     <= sio_c_d;
            sio_d_q     <= sio_d_d;
            oe_q        <= oe_d;
            cntr_en_q   <= cntr_en_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign busy_o      = busy_q;
    assign cntr_en_o   = cntr_en_q;
    assign sio_c_o     = sio_c_q;
    assign sio_d_o     = sio_d_q;
    assign sio_d_oe_o  = oe_q;

endmodule

// File: tb/tb_smc_sccb_master_fsm.sv
// Bench for the SCCB master sequencer: timing-generator model, bus monitor with
// a simple read slave, and per-transaction checks against an expected bit stream.
module tb_smc_sccb_master_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_rw_i = 1'b0;
    logic [6:0] req_id_i = '0;
    logic [7:0] req_addr_i = '0;
    logic [7:0] req_wdata_i = '0;
    logic       req_ready_o, rsp_valid_o, busy_o, cntr_en_o;
    logic [7:0] rsp_rdata_o;
    logic       tick_en_i, sio_c_tgl_en_i;
    logic       sio_c_o, sio_d_o, sio_d_oe_o, sio_d_i;

    smc_sccb_master_fsm #(.DATA_W(8), .ID_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rw_i(req_rw_i), .req_id_i(req_id_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .busy_o(busy_o), .cntr_en_o(cntr_en_o),
        .tick_en_i(tick_en_i), .sio_c_tgl_en_i(sio_c_tgl_en_i),
        .sio_c_o(sio_c_o), .sio_d_o(sio_d_o), .sio_d_oe_o(sio_d_oe_o),
        .sio_d_i(sio_d_i)
    );

    always #5 clk = ~clk;

    // Timing generator: half-period of hcyc cycles, tick mid-way, toggle at the end.
    int hcyc = 8;
    int gcnt = 0;
    always @(posedge clk) begin
        if (!cntr_en_o) gcnt <= 0;
        else if (gcnt >= hcyc - 1) gcnt <= 0;
        else gcnt <= gcnt + 1;
    end
    assign tick_en_i      = cntr_en_o && (gcnt == ((hcyc > 1) ? hcyc / 2 - 1 : 0));
    assign sio_c_tgl_en_i = cntr_en_o && (gcnt == hcyc - 1);

    // Open-drain bus with pull-up; the slave releases (1) except when returning data.
    logic       slv_d = 1'b1;
    logic [7:0] slv_byte = '0;
    assign sio_d_i = sio_d_oe_o ? sio_d_o : slv_d;

    function automatic logic slave_bit(input int idx, input logic rd);
        if (rd && idx >= 9 && idx <= 16) return slv_byte[16 - idx];
        return 1'b1;
    endfunction

    logic prev_c = 1'b1, prev_b = 1'b1, srw = 1'b0;
    int   scnt = 0, rise_n = 0, tgl_n = 0, rsp_n = 0, starts_n = 0, stops_n = 0;
    logic rec_oe [4096];
    logic rec_d  [4096];

    // Records bus level/oe at each data-clock rising edge; the clock edge of a STOP is dropped.
    always @(negedge clk) begin
        prev_c <= sio_c_o;
        prev_b <= sio_d_i;
        if (sio_c_tgl_en_i) tgl_n <= tgl_n + 1;
        if (rsp_valid_o) rsp_n <= rsp_n + 1;
        if (rst) begin
            scnt  <= 0;
            srw   <= 1'b0;
            slv_d <= 1'b1;
        end else begin
            if (prev_c && sio_c_o && prev_b && !sio_d_i) begin
                starts_n <= starts_n + 1;
                scnt     <= 0;
                srw      <= 1'b0;
            end else if (prev_c && sio_c_o && !prev_b && sio_d_i) begin
                stops_n <= stops_n + 1;
                scnt    <= 0;
                srw     <= 1'b0;
                if (rise_n > 0) rise_n <= rise_n - 1;
            end else if (!prev_c && sio_c_o) begin
                if (rise_n < 4096) begin
                    rec_oe[rise_n] <= sio_d_oe_o;
                    rec_d[rise_n]  <= sio_d_i;
                end
                rise_n <= rise_n + 1;
                scnt   <= scnt + 1;
                if (scnt == 7) srw <= sio_d_i;
            end
            if (!sio_c_o) slv_d <= slave_bit(scnt, srw);
        end
    end

    int n_checks = 0, n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int r0, t0, s0, p0, q0;

    task automatic snap();
        r0 = rise_n; t0 = tgl_n; s0 = starts_n; p0 = stops_n; q0 = rsp_n;
    endtask

    // Expected: each phase is 8 driven bits then a released bit; a read's RDATA
    // phase is 8 released bits (slave data) then a driven-1 NA bit.
    task automatic verify(input string nm, input logic rw, input logic [6:0] id,
                          input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] sb);
        logic [7:0] bytes[$];
        int         nseg;
        logic [8:0] got_d, got_oe, exp_oe;
        bytes.push_back({id, 1'b0});
        bytes.push_back(addr);
        if (rw) begin
            bytes.push_back({id, 1'b1});
            bytes.push_back(sb);
        end else begin
            bytes.push_back(wdata);
        end
        nseg = rw ? 2 : 1;
        check_eq({nm, "_edges"}, rise_n - r0, 9 * bytes.size());
        check_eq({nm, "_halfper"}, tgl_n - t0, 3 * nseg + 18 * bytes.size());
        check_eq({nm, "_stops"}, stops_n - p0, nseg);
        if (hcyc > 1) check_eq({nm, "_starts"}, starts_n - s0, nseg);
        check_eq({nm, "_rsp_cnt"}, rsp_n - q0, 1);
        for (int p = 0; p < bytes.size(); p++) begin
            for (int k = 0; k < 9; k++) begin
                got_d[8 - k]  = rec_d[(r0 + 9 * p + k) % 4096];
                got_oe[8 - k] = rec_oe[(r0 + 9 * p + k) % 4096];
            end
            exp_oe = (rw && p == 3) ? 9'b000000001 : 9'b111111110;
            check_eq($sformatf("%s_ph%0d_d", nm, p), got_d, {bytes[p], 1'b1});
            check_eq($sformatf("%s_ph%0d_oe", nm, p), got_oe, exp_oe);
        end
        if (rw) check_eq({nm, "_rdata"}, rsp_rdata_o, sb);
    endtask

    task automatic send(input logic rw, input logic [6:0] id, input logic [7:0] addr,
                        input logic [7:0] wdata);
        int g;
        req_rw_i = rw; req_id_i = id; req_addr_i = addr; req_wdata_i = wdata;
        req_valid_i = 1'b1;
        g = 0;
        while (!req_ready_o && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic run_txn(input string nm, input logic rw, input logic [6:0] id,
                           input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] sb, input bit watch, input logic [7:0] hold);
        int g, bad;
        slv_byte = sb;
        snap();
        send(rw, id, addr, wdata);
        g = 0; bad = 0;
        while (!rsp_valid_o && g < 4000) begin
            if (watch && rsp_rdata_o !== hold) bad++;
            @(negedge clk);
            g++;
        end
        check_eq({nm, "_rsp_seen"}, rsp_valid_o, 1'b1);
        if (watch) check_eq({nm, "_rdata_hold"}, bad, 0);
        @(negedge clk);
        check_eq({nm, "_rsp_one_cycle"}, rsp_valid_o, 1'b0);
        verify(nm, rw, id, addr, wdata, sb);
    endtask

    initial begin : main
        int g, k, bad;
        logic       rw;
        logic [6:0] id;
        logic [7:0] a, w, s;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", req_ready_o, 1'b1);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_rsp", rsp_valid_o, 1'b0);
        check_eq("rst_rdata", rsp_rdata_o, 8'h00);
        check_eq("rst_cntr_en", cntr_en_o, 1'b0);
        check_eq("rst_sio_c", sio_c_o, 1'b1);
        check_eq("rst_sio_d", sio_d_o, 1'b1);
        check_eq("rst_oe", sio_d_oe_o, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        hcyc = 8;
        run_txn("wr", 1'b0, 7'h21, 8'h12, 8'h80, 8'h00, 1'b0, 8'h00);
        run_txn("rd", 1'b1, 7'h21, 8'h0A, 8'h00, 8'hC5, 1'b0, 8'h00);

        // Back-pressure: request B is held valid throughout request A.
        slv_byte = 8'hFF;
        snap();
        req_rw_i = 1'b0; req_id_i = 7'h21; req_addr_i = 8'h34; req_wdata_i = 8'h5A;
        req_valid_i = 1'b1;
        @(negedge clk);
        req_id_i = 7'h3C; req_addr_i = 8'hA7; req_wdata_i = 8'h0F;
        g = 0; bad = 0;
        while (!rsp_valid_o && g < 4000) begin
            if (req_ready_o) bad++;
            @(negedge clk);
            g++;
        end
        check_eq("bp_rsp_seen", rsp_valid_o, 1'b1);
        check_eq("bp_ready_low", bad, 0);
        @(negedge clk);
        check_eq("bp_ready_after_done", req_ready_o, 1'b1);
        verify("bpA", 1'b0, 7'h21, 8'h34, 8'h5A, 8'hFF);
        snap();
        @(negedge clk);
        check_eq("bp_accept_busy", busy_o, 1'b1);
        check_eq("bp_accept_ready", req_ready_o, 1'b0);
        req_valid_i = 1'b0;
        g = 0;
        while (!rsp_valid_o && g < 4000) begin
            @(negedge clk);
            g++;
        end
        check_eq("bpB_rsp_seen", rsp_valid_o, 1'b1);
        @(negedge clk);
        verify("bpB", 1'b0, 7'h3C, 8'hA7, 8'h0F, 8'hFF);

        // Abort a write with reset while its 20th toggle pulse is present.
        q0 = rsp_n;
        req_rw_i = 1'b0; req_id_i = 7'h21; req_addr_i = 8'h12; req_wdata_i = 8'h80;
        req_valid_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        k = 0; g = 0;
        while (k < 20 && g < 4000) begin
            if (sio_c_tgl_en_i) k++;
            if (k < 20) begin
                @(negedge clk);
                g++;
            end
        end
        check_eq("rst20_reached", k, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst20_sio_c", sio_c_o, 1'b1);
        check_eq("rst20_sio_d", sio_d_o, 1'b1);
        check_eq("rst20_oe", sio_d_oe_o, 1'b1);
        check_eq("rst20_cntr_en", cntr_en_o, 1'b0);
        check_eq("rst20_rsp", rsp_valid_o, 1'b0);
        check_eq("rst20_ready", req_ready_o, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("rst20_no_rsp", rsp_n - q0, 0);
        run_txn("wr_after_rst", 1'b0, 7'h21, 8'h12, 8'h80, 8'h00, 1'b0, 8'h00);

        hcyc = 1;
        run_txn("wr_h1", 1'b0, 7'h21, 8'h12, 8'h80, 8'h00, 1'b0, 8'h00);

        hcyc = 8;
        run_txn("rd_b2b1", 1'b1, 7'h21, 8'h40, 8'h00, 8'h11, 1'b0, 8'h00);
        run_txn("rd_b2b2", 1'b1, 7'h21, 8'h41, 8'h00, 8'h22, 1'b1, 8'h11);

        for (int i = 0; i < 12; i++) begin
            hcyc = $urandom_range(1, 10);
            rw = 1'($urandom);
            id = 7'($urandom);
            a  = 8'($urandom);
            w  = 8'($urandom);
            s  = 8'($urandom);
            run_txn($sformatf("rnd%0d", i), rw, id, a, w, s, 1'b0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
